// File: rtl/imm_encoder_pkg.sv
// imm_encoder_pkg: immediate-type codes, opcodes, stage-A record and range-check helper
package imm_encoder_pkg;
  localparam logic [2:0] R_TYPE     = 3'd0;
  localparam logic [2:0] I_TYPE     = 3'd1;
  localparam logic [2:0] ISTAR_TYPE = 3'd2;
  localparam logic [2:0] S_TYPE     = 3'd3;
  localparam logic [2:0] B_TYPE     = 3'd4;
  localparam logic [2:0] U_TYPE     = 3'd5;
  localparam logic [2:0] J_TYPE     = 3'd6;
  localparam logic [6:0] OP_IMM     = 7'h13;
  localparam logic [6:0] OP_REG     = 7'h33;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_JAL     = 7'h6f;
  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } enc_in_t;
  // true when imm[31:lsb] are all equal, i.e. imm fits as a signed (lsb+1)-bit value
  function automatic logic sext_ok(input logic [31:0] v, input int unsigned lsb);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << lsb;
    return ((v & m) == m) || ((v & m) == 32'h0);
  endfunction
endpackage

// File: rtl/imm_encode_dp.sv
// imm_encode_dp: combinational immediate scatter into an RV32I word plus representability check
module imm_encode_dp
  import imm_encoder_pkg::*;
(
  input  enc_in_t     f,
  output logic [31:0] inst,
  output logic        err
);
  always_comb begin
    inst = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
    err  = 1'b0;
    case (f.imm_type)
      I_TYPE: begin
        inst[31:20] = f.imm[11:0];
        err = !sext_ok(f.imm, 11);
      end
      ISTAR_TYPE: begin
        inst[24:20] = f.imm[4:0];
        err = |f.imm[31:5];
      end
      S_TYPE: begin
        inst[31:25] = f.imm[11:5];
        inst[11:7]  = f.imm[4:0];
        err = !sext_ok(f.imm, 11);
      end
      B_TYPE: begin
        inst[31:25] = {f.imm[12], f.imm[10:5]};
        inst[11:7]  = {f.imm[4:1], f.imm[11]};
        err = f.imm[0] || !sext_ok(f.imm, 12);
      end
      U_TYPE: begin
        inst[31:12] = f.imm[31:12];
        err = |f.imm[11:0];
      end
      J_TYPE: begin
        inst[31:12] = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12]};
        err = f.imm[0] || !sext_ok(f.imm, 20);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/imm_encoder.sv
// imm_encoder: 2-stage ready/valid pipeline around imm_encode_dp with a saturating error counter
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      imm,
  input  logic [2:0]       imm_type,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             imm_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] err_count
);
  enc_in_t           a_q, a_d;
  logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d, b_load;
  logic [31:0]       inst_q, inst_d, dp_inst;
  logic              err_q, err_d, dp_err;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  imm_encode_dp u_dp (.f(a_q), .inst(dp_inst), .err(dp_err));
  always_comb begin
    b_load    = !b_valid_q || out_ready;
    in_ready  = !a_valid_q || b_load;
    a_valid_d = in_ready ? in_valid : a_valid_q;
    a_d       = (in_valid && in_ready) ? {imm, imm_type, opcode, rd, rs1, rs2, funct3, funct7} : a_q;
    b_valid_d = b_load ? a_valid_q : b_valid_q;
    inst_d    = (b_load && a_valid_q) ? dp_inst : inst_q;
    err_d     = (b_load && a_valid_q) ? dp_err : err_q;
    cnt_d     = err_clr ? '0 : (b_valid_q && out_ready && err_q && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q       <= '0;
      a_valid_q <= 1'b0;
      b_valid_q <= 1'b0;
      inst_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      a_q       <= a_d;
      a_valid_q <= a_valid_d;
      b_valid_q <= b_valid_d;
      inst_q    <= inst_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end
  assign out_valid = b_valid_q;
  assign inst      = inst_q;
  assign imm_err   = err_q;
  assign err_count = cnt_q;
endmodule

// File: doc/imm_encoder.md
# imm_encoder

Pipelined immediate encoder: the inverse of the stage-1 immediate generator. It accepts an immediate value, an immediate-type code and the non-immediate instruction fields, checks that the immediate is representable, and scatters its bits into a 32-bit RV32I instruction word. It feeds the instruction-memory preload/self-test path and the verification harness, which round-trips its output through the stage-1 immediate generator. It has a ready/valid handshake on both sides, a 2-stage pipeline and a saturating error counter.

## Interface
- CNT_W, 16: width of the error counter.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  encoder can accept this cycle.
- imm  in  32  immediate value, two's complement.
- imm_type  in  3  immediate type; encodings I_TYPE, ISTAR_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE from stage1/stage1_control.vh. Any other value means no immediate (R-type).
- opcode  in  7  inst[6:0].
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  inst[14:12].
- funct7  in  7  inst[31:25]; used only for R and I* types.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  downstream accepts.
- inst  out  32  encoded instruction.
- imm_err  out  1  immediate not representable for imm_type; qualified by out_valid.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  CNT_W  saturating count of delivered transactions with imm_err=1.

## Operation
- Scatter rules (bits not listed come from the field inputs):
  - R: {funct7, rs2, rs1, funct3, rd, opcode}. imm ignored, imm_err=0.
  - I: inst[31:20]=imm[11:0]. Error if imm[31:11] are not all equal.
  - I*: inst[31:25]=funct7, inst[24:20]=imm[4:0]. Error if imm[31:5]!=0.
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0]. Error as for I.
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11]. Error if imm[0]=1 or imm[31:12] are not all equal.
  - U: inst[31:12]=imm[31:12]. Error if imm[11:0]!=0.
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12]. Error if imm[0]=1 or imm[31:20] are not all equal.
- On error the word is still emitted with the truncated bits as listed. imm_err flags the error. The transaction is never dropped.
- err_count increments by 1 on each output handshake (out_valid and out_ready) with imm_err=1. It saturates at all-ones.
- err_clr has priority over increment: if a clear and an errored handshake occur in the same cycle, the result is 0.

## Timing
- Stage A register: captures the raw inputs on an input handshake (in_valid and in_ready).
- Stage B register: holds inst and imm_err computed combinationally from stage A.
- Latency: 2 cycles from input handshake to out_valid. Throughput is 1 per cycle under continuous out_ready.
- Stage B loads when it is empty or draining (out_ready=1).
- Stage A advances when stage B loads.
- in_ready = !A_valid || (B loads this cycle). in_ready depends combinationally on out_ready.
- With out_ready=0, both stages hold: inst, imm_err and out_valid stay stable. At most 2 transactions are in flight, after which in_ready=0.
- Reset (asynchronous, any time including mid-transfer): both valid bits, inst, imm_err and err_count go to 0. In-flight transactions are discarded. in_ready=1 once reset is deasserted.

## Structure
- Add to stage1/stage1_control.vh: the imm_type encodings (shared with the immediate generator) and opcode constants used by the bench.
- Sub-module imm_encode_dp: purely combinational scatter plus range check; inputs imm, imm_type and fields; outputs inst and err.
- imm_encoder contains only the two pipeline registers, the handshake logic and err_count.

## Test plan
- Sweep each type with boundary immediates: I with 2047 and -2048; B with 4094 and -4096; J with 0xFFFFE and 0xFFF00000. Feed inst[31:7] into the stage-1 immediate generator with the same imm_type; the result equals imm, and imm_err=0.
- I with imm=2048 produces inst[31:20]=0x800 and imm_err=1. B with imm=3 produces imm_err=1. U with imm=0x12345001 produces imm_err=1 and inst[31:12]=0x12345. err_count ends at 3.
- Stream 8 back-to-back transactions with out_ready=1: out_valid is high for 8 consecutive cycles starting 2 cycles after the first accept, and outputs arrive in order.
- Hold out_ready=0 for 5 cycles: in_ready falls after 2 accepts and inst stays stable. Release: both words drain, then the next input is accepted.
- With CNT_W=2, make 5 errored handshakes: err_count saturates at 3. err_clr coinciding with an errored handshake gives err_count=0.
- Assert reset with 2 words in flight: out_valid=0 and err_count=0 immediately, with no stale output after release.
